edge_event_unit: RTL

Multi-channel edge event detector; next generation of the single-bit edge detector. Each channel synchronises an asynchronous input, glitch-filters it, detects rising, falling or both edges under a run-time per-channel mode, and records events in sticky status bits that drive one masked interrupt. It sits between external/slow-domain status lines and the register block, which clears status and reads event counts.

---
 rtl/edge_event_unit_pkg.sv | 32 +++
 rtl/edge_event_unit_if.sv | 29 ++
 rtl/edge_event_unit_ch.sv | 102 ++++++++++
 rtl/edge_event_unit.sv | 60 ++++++
 4 files changed

// File: rtl/edge_event_unit_pkg.sv
// Shared types and helpers for the multi-channel edge event unit.
// Optional per-channel event counters are enabled with EDGE_EVENT_CNT_EN.
package edge_event_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

    typedef enum logic {
        FILT_STABLE  = 1'b0,
        FILT_QUALIFY = 1'b1
    } filt_state_e;

    // Width of the glitch-filter counter; it must hold values up to FILTER_LEN.
    function automatic int filt_cnt_w(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction

    // True when a level change to new_level qualifies under mode.
    function automatic logic edge_hit(input edge_mode_e mode, input logic new_level);
        case (mode)
            EDGE_RISE: return new_level;
            EDGE_FALL: return !new_level;
            EDGE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_event_unit_if.sv
// Register-block facing bundle of the edge event unit.
// cnt_clr / evt_cnt exist only when EDGE_EVENT_CNT_EN is defined.
interface edge_event_unit_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]   in;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   evt_clr;
    logic [NUM_CH-1:0]   irq_mask;
    logic [NUM_CH-1:0]   edge_pulse;
    logic [NUM_CH-1:0]   level;
    logic [NUM_CH-1:0]   evt_status;
    logic                irq;
`ifdef EDGE_EVENT_CNT_EN
    logic [NUM_CH-1:0]       cnt_clr;
    logic [CNT_W*NUM_CH-1:0] evt_cnt;

    modport master (output in, mode, evt_clr, irq_mask, cnt_clr,
                    input  edge_pulse, level, evt_status, irq, evt_cnt);
    modport slave  (input  in, mode, evt_clr, irq_mask, cnt_clr,
                    output edge_pulse, level, evt_status, irq, evt_cnt);
`else
    modport master (output in, mode, evt_clr, irq_mask,
                    input  edge_pulse, level, evt_status, irq);
    modport slave  (input  in, mode, evt_clr, irq_mask,
                    output edge_pulse, level, evt_status, irq);
`endif
endinterface

// File: rtl/edge_event_unit_ch.sv
// One channel: synchroniser, glitch filter FSM, edge detect, sticky flag
// and (with EDGE_EVENT_CNT_EN) a saturating event counter.
module edge_event_ch
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
`ifdef EDGE_EVENT_CNT_EN
    ,parameter int CNT_W      = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  edge_mode_e       mode,
    input  logic             evt_clr,
    output logic             edge_pulse,
    output logic             level,
    output logic             evt_status
`ifdef EDGE_EVENT_CNT_EN
    ,input  logic            cnt_clr
    ,output logic [CNT_W-1:0] evt_cnt
`endif
);
    localparam int FW = filt_cnt_w(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    filt_state_e            state;
    logic [FW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    // Metastability chain on the raw asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], in};
    end

    // Glitch filter: a new level must persist FILTER_LEN cycles; the pulse
    // is registered on the same edge that commits the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILT_STABLE;
            cnt        <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= 1'b0;
            case (state)
                FILT_STABLE: begin
                    if (s != level) begin
                        if (FILTER_LEN == 1) begin
                            level      <= s;
                            edge_pulse <= edge_hit(mode, s);
                        end else begin
                            state <= FILT_QUALIFY;
                            cnt   <= FW'(1);
                        end
                    end
                end
                FILT_QUALIFY: begin
                    if (s == level) begin
                        state <= FILT_STABLE;
                        cnt   <= '0;
                    end else if (cnt == FW'(FILTER_LEN - 1)) begin
                        state      <= FILT_STABLE;
                        cnt        <= '0;
                        level      <= s;
                        edge_pulse <= edge_hit(mode, s);
                    end else begin
                        cnt <= cnt + FW'(1);
                    end
                end
                default: begin
                    state <= FILT_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky event flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          evt_status <= 1'b0;
        else if (edge_pulse) evt_status <= 1'b1;
        else if (evt_clr)    evt_status <= 1'b0;
    end

`ifdef EDGE_EVENT_CNT_EN
    // Saturating event counter; clear with a coincident event restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            evt_cnt <= '0;
        else if (cnt_clr)
            evt_cnt <= edge_pulse ? CNT_W'(1) : '0;
        else if (edge_pulse && evt_cnt != '1)
            evt_cnt <= evt_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event detector: NUM_CH channel instances plus a
// registered masked interrupt. Define EDGE_EVENT_CNT_EN for event counters.
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    edge_event_unit_if.slave  bus
);
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] status;
    logic              irq_q;
`ifdef EDGE_EVENT_CNT_EN
    logic [CNT_W*NUM_CH-1:0] cnt;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_event_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
`ifdef EDGE_EVENT_CNT_EN
            ,.CNT_W      (CNT_W)
`endif
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .in          (bus.in[i]),
            .mode        (edge_mode_e'(bus.mode[2*i +: 2])),
            .evt_clr     (bus.evt_clr[i]),
            .edge_pulse  (pulse[i]),
            .level       (lvl[i]),
            .evt_status  (status[i])
`ifdef EDGE_EVENT_CNT_EN
            ,.cnt_clr    (bus.cnt_clr[i])
            ,.evt_cnt    (cnt[CNT_W*i +: CNT_W])
`endif
        );
    end

    // Interrupt follows the masked sticky flags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= |(status & bus.irq_mask);
    end

    assign bus.edge_pulse = pulse;
    assign bus.level      = lvl;
    assign bus.evt_status = status;
    assign bus.irq        = irq_q;
`ifdef EDGE_EVENT_CNT_EN
    assign bus.evt_cnt    = cnt;
`endif

endmodule
